// File: rtl/izero_pkg.sv
// Constants shared by the control unit and the interrupt controller:
// cause codes, controller state encoding and the control-flow opcodes.
package izero_pkg;

   localparam logic [5:0] INTR_NONE    = 6'd0;
   localparam logic [5:0] INTR_TIMER   = 6'd1;
   localparam logic [5:0] INTR_IO      = 6'd2;
   localparam logic [5:0] INTR_SYSCALL = 6'd3;
   localparam logic [5:0] INTR_HALT    = 6'd4;

   localparam logic [5:0] OP_J     = 6'b111100;
   localparam logic [5:0] OP_JTM   = 6'b111101;
   localparam logic [5:0] OP_JAL   = 6'b111110;
   localparam logic [5:0] OP_JF    = 6'b010101;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] FUNC_JR  = 6'b010010;

   typedef enum logic [1:0] {
      S_KERNEL = 2'd0,
      S_USER   = 2'd1,
      S_IRQ    = 2'd2,
      S_WAIT   = 2'd3
   } estado_t;

   // A cause may only be taken when the issuing instruction does not redirect the PC.
   function automatic logic ponto_seguro(input logic [5:0] op, input logic [5:0] func);
      logic salto;
      salto = (op == OP_J) || (op == OP_JTM) || (op == OP_JAL) || (op == OP_JF) ||
              ((op == OP_RTYPE) && (func == FUNC_JR));
      return !salto;
   endfunction

endpackage

// File: rtl/gerenciador_interrupcao_contador_quantum.sv
// Quantum counter: counts enabled cycles and pulses expire on the last count of
// the quantum, wrapping back to zero in the same cycle.
module contador_quantum
   import izero_pkg::*;
#(
   parameter int unsigned          QUANTUM_W = 16,
   parameter logic [QUANTUM_W-1:0] QUANTUM   = 16'd500
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam logic [QUANTUM_W-1:0] ULTIMO = QUANTUM - 1'b1;

   logic [QUANTUM_W-1:0] conta_q, conta_d;

   assign expire = enable && (conta_q == ULTIMO);

   always_comb begin
      conta_d = conta_q;
      if (clear) begin
         conta_d = '0;
      end else if (enable) begin
         conta_d = expire ? '0 : conta_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         conta_q <= '0;
      end else begin
         conta_q <= conta_d;
      end
   end

endmodule

// File: rtl/gerenciador_interrupcao.sv
// Interrupt controller behind the control unit's intr/inta/clearIntr handshake.
// Optional serviced-interrupt counter enabled by defining IRQ_COUNT_EN.
module gerenciador_interrupcao
   import izero_pkg::*;
#(
   parameter int unsigned          QUANTUM_W = 16,
   parameter logic [QUANTUM_W-1:0] QUANTUM   = 16'd500,
   parameter int unsigned          PC_W      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [5:0]      op,
   input  logic [5:0]      func,
   input  logic [PC_W-1:0] pc,
   input  logic            userMode,
   input  logic            kernelMode,
   input  logic            isHalt,
   input  logic            inta,
   input  logic            inputDone,
   input  logic            clearIntr,
   output logic            intr,
   output logic [5:0]      intrCode,
   output logic [PC_W-1:0] intrPC,
   output logic            isUser,
   output logic [31:0]     intrCount
);

   estado_t         estado_q, estado_d;
   logic [5:0]      codigo_q, codigo_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            tmr_pend_q, tmr_pend_d;
   logic            io_pend_q, io_pend_d;
   logic            io_armado_q, io_armado_d;
   logic            expira, limpa_quantum;

   contador_quantum #(
      .QUANTUM_W (QUANTUM_W),
      .QUANTUM   (QUANTUM)
   ) u_contador_quantum (
      .clk    (clk),
      .rst    (rst),
      .enable (estado_q == S_USER),
      .clear  (limpa_quantum),
      .expire (expira)
   );

   always_comb begin
      estado_d      = estado_q;
      codigo_d      = codigo_q;
      pc_d          = pc_q;
      limpa_quantum = 1'b0;
      // Events landing this cycle count as pending so they can win immediately.
      tmr_pend_d    = tmr_pend_q | expira;
      io_pend_d     = io_pend_q | inputDone;
      io_armado_d   = io_armado_q | (inta && (estado_q == S_USER));

      unique case (estado_q)
         S_KERNEL: begin
            if (userMode) begin
               estado_d      = S_USER;
               limpa_quantum = 1'b1;
            end
         end
         S_USER: begin
            if (kernelMode) begin
               // Control unit already redirects the PC on syscall, so no intr pulse.
               estado_d = S_WAIT;
               codigo_d = INTR_SYSCALL;
               pc_d     = pc;
            end else if (ponto_seguro(op, func)) begin
               if (isHalt) begin
                  estado_d = S_IRQ;
                  codigo_d = INTR_HALT;
                  pc_d     = pc;
               end else if (io_pend_d) begin
                  estado_d    = S_IRQ;
                  codigo_d    = INTR_IO;
                  pc_d        = pc;
                  io_pend_d   = 1'b0;
                  io_armado_d = 1'b0;
               end else if (tmr_pend_d) begin
                  estado_d   = S_IRQ;
                  codigo_d   = INTR_TIMER;
                  pc_d       = pc;
                  tmr_pend_d = 1'b0;
               end
            end
         end
         S_IRQ: begin
            estado_d = S_WAIT;
         end
         S_WAIT: begin
            if (userMode) begin
               estado_d      = S_USER;
               codigo_d      = INTR_NONE;
               limpa_quantum = 1'b1;
            end else if (clearIntr) begin
               estado_d = S_KERNEL;
               codigo_d = INTR_NONE;
            end
         end
         default: begin
            estado_d = S_KERNEL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         estado_q    <= S_KERNEL;
         codigo_q    <= INTR_NONE;
         pc_q        <= '0;
         tmr_pend_q  <= 1'b0;
         io_pend_q   <= 1'b0;
         io_armado_q <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         codigo_q    <= codigo_d;
         pc_q        <= pc_d;
         tmr_pend_q  <= tmr_pend_d;
         io_pend_q   <= io_pend_d;
         io_armado_q <= io_armado_d;
      end
   end

   assign intr     = (estado_q == S_IRQ);
   assign isUser   = (estado_q == S_USER);
   assign intrCode = codigo_q;
   assign intrPC   = pc_q;

`ifdef IRQ_COUNT_EN
   logic [31:0] contagem_q;
   logic        entra_espera;

   assign entra_espera = (estado_d == S_WAIT) && (estado_q != S_WAIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         contagem_q <= '0;
      end else if (entra_espera && (contagem_q != 32'hFFFF_FFFF)) begin
         contagem_q <= contagem_q + 32'd1;
      end
   end

   assign intrCount = contagem_q;
`else
   assign intrCount = 32'd0;
`endif

endmodule

// File: doc/gerenciador_interrupcao.md
Name: gerenciador_interrupcao

Overview:
- Interrupt controller on the far end of the control unit's `intr`/`inta`/`clearIntr` handshake.
- Collects interrupt causes: quantum expiry, I/O input completion, syscall, and user-mode halt.
- Prioritises them, raises `intr` toward the control unit at a safe instruction boundary, and holds the cause code and resume PC.
- Kernel reads the held values with `gic`/`gip` and releases them with `cic`.
- Also tracks the processor execution mode (kernel/user).

Parameters:
- QUANTUM_W, 16, width of the quantum counter.
- QUANTUM, 16'd500, user-mode cycles before a timer interrupt.
- PC_W, 32, width of the program counter and of `intrPC`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- op  in  6  opcode of the instruction issuing this cycle.
- func  in  6  function field of the instruction issuing this cycle.
- pc  in  PC_W  address of the instruction issuing this cycle.
- userMode  in  1  exec/exec_again decoded this cycle.
- kernelMode  in  1  syscall decoded this cycle.
- isHalt  in  1  halt decoded this cycle.
- inta  in  1  interrupt acknowledge from the control unit (`pre_io` or `intr`).
- inputDone  in  1  one-cycle pulse: the input device has delivered data.
- clearIntr  in  1  `cic` decoded this cycle.
- intr  out  1  interrupt request to the control unit.
- intrCode  out  6  latched cause (0 none, 1 timer, 2 I/O, 3 syscall, 4 halt).
- intrPC  out  PC_W  resume address of the interrupted program.
- isUser  out  1  1 while in user mode.
- intrCount  out  32  serviced-interrupt counter (optional feature).

Behaviour:
- All state updates on `posedge clk`.
- Reset (`rst`=0, synchronous): state S_KERNEL; `intr`=0, `intrCode`=0, `intrPC`=0, `isUser`=0; counter 0; pending bits cleared.
- States:
  - S_KERNEL: kernel executing, no cause held.
  - S_USER: user program executing.
  - S_IRQ: one-cycle request state.
  - S_WAIT: kernel servicing, cause held.
- S_KERNEL:
  - `userMode` → S_USER; quantum counter cleared; `isUser`=1 from the next cycle.
- S_USER:
  - Quantum counter increments every cycle.
  - Counter at QUANTUM-1 sets `tmr_pend` and wraps to 0.
  - `inputDone` sets `io_pend` (sticky; also sampled in any other state, but only taken in S_USER).
  - `inta` with opcode `pre_io` only arms the I/O path; it raises nothing.
  - Syscall (`kernelMode`=1) takes precedence over everything else:
    - `intrCode`=3 and `intrPC`=`pc`; next state S_WAIT.
    - `isUser`=0 next cycle.
    - No `intr` pulse; the control unit already redirects the PC.
  - Otherwise, a cause is taken only at a safe point. The issuing instruction must not be j, jtm, jal, jf (`op` 111100/111101/111110/010101), or R-type with `func` 010010 (jr).
  - Priority at a safe point: halt (`isHalt`) → code 4; `io_pend` → 2; `tmr_pend` → 1.
  - The winner's pending bit is cleared; lower pending bits stay set.
  - Taking a cause latches `intrCode` and `intrPC`=`pc`, and moves to S_IRQ.
- S_IRQ:
  - `intr`=1 for exactly one cycle; `isUser`=0.
  - Next state S_WAIT unconditionally.
- S_WAIT:
  - `intrCode`/`intrPC` are held stable.
  - `clearIntr` → `intrCode`=0, next state S_KERNEL.
  - `userMode` without a prior clear is an implicit clear: → S_USER, counter cleared, `intrCode`=0.
  - Further timer/I/O events only set pending bits.
- Latency: cause sampled at cycle N → `intr` high at N+1, S_WAIT at N+2.
- Simultaneous `clearIntr` and `userMode` in S_WAIT: `userMode` wins (→ S_USER).
- Quantum expiry on an unsafe instruction: stays pending and is taken at the next safe point.
- Reset asserted mid-request: all state abandoned and pending bits lost.

Optional Feature:
- Macro: IRQ_COUNT_EN.
- Defined:
  - `intrCount` increments by 1 on every entry to S_WAIT (both syscall and `intr` paths).
  - Saturates at 32'hFFFFFFFF; cleared by reset.
- Undefined: `intrCount` tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package `izero_pkg` holds:
  - cause codes (INTR_NONE/TIMER/IO/SYSCALL/HALT);
  - state encoding;
  - opcode constants OP_J, OP_JTM, OP_JAL, OP_JF, OP_RTYPE and FUNC_JR.
  - The control unit and this block share these opcode constants.
- One sub-module, `contador_quantum`:
  - inputs: enable, clear;
  - output: one-cycle expire pulse at QUANTUM-1;
  - parameterised by QUANTUM_W and QUANTUM.

Test Plan:
- Reset, then `userMode` pulse with no other events for 500 cycles → `intr`=1 exactly one cycle later; `intrCode`=1; `intrPC`=`pc` of the expiry cycle; `isUser`=0.
- `inputDone` and quantum expiry in the same cycle in user mode → `intrCode`=2 first. After `clearIntr` and `userMode`, the next safe cycle raises `intr` with `intrCode`=1.
- `op`=111001 (syscall) with `pc`=32'h40 in user mode → `intr` stays 0; `intrCode`=3; `intrPC`=32'h40; `clearIntr` returns `intrCode` to 0.
- Quantum expires while `op`=111110 (jal) for 3 cycles → `intr` deferred until the first cycle with a safe opcode, then `intrCode`=1.
- `rst`=0 for one cycle while in S_WAIT holding code 4 → next cycle: all outputs 0, state S_KERNEL, pending bits cleared.
- With IRQ_COUNT_EN: 3 timer interrupts plus 1 syscall → `intrCount`=4. Without the macro → `intrCount`=0 throughout.
